// File: rtl/relu_maxpool_2x2_if.sv
// ---------------------------------------------------------------------------
// relu_maxpool_2x2_if
// Bundles the pixel stream that enters the ReLU / 2x2 max-pool stage and the
// pooled stream that leaves it.
//
// Signals:
//   in_data     [DATA_W]  convolution pixel, two's complement
//   in_valid              in_data is valid this cycle
//   in_row_end            last pixel of a row (qualified by in_valid)
//   in_done               one-cycle frame-complete pulse
//   out_data    [DATA_W]  pooled pixel, always non-negative
//   out_valid             one-cycle pulse per pooled pixel
//   out_row_end           one-cycle pulse closing a pooled row
//   out_done              one-cycle frame-complete pulse
//   overflow              sticky, a row was wider than the line buffer allows
//
// Modports:
//   master  - the producer side (drives in_*, observes out_* and overflow)
//   slave   - the pooling stage itself
// ---------------------------------------------------------------------------
interface relu_maxpool_2x2_if #(
    parameter int DATA_W = 24
);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_row_end;
    logic              in_done;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_row_end;
    logic              out_done;
    logic              overflow;

    modport master (
        output in_data, in_valid, in_row_end, in_done,
        input  out_data, out_valid, out_row_end, out_done, overflow
    );

    modport slave (
        input  in_data, in_valid, in_row_end, in_done,
        output out_data, out_valid, out_row_end, out_done, overflow
    );
endinterface

// File: rtl/relu_maxpool_2x2.sv
// ---------------------------------------------------------------------------
// relu_maxpool_2x2
// Streaming ReLU followed by a 2x2 max-pool over a raster-order pixel stream.
// Negative pixels are clamped to zero, horizontal pairs are reduced in a pair
// register, and the pair maxima of even rows are parked in a half-width line
// buffer until the matching pair of the following odd row arrives.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    slave side of relu_maxpool_2x2_if (input stream in, pooled out)
//
// Parameters:
//   DATA_W    pixel width
//   MAX_COLS  maximum input columns per row, even and at least 4
// ---------------------------------------------------------------------------
module relu_maxpool_2x2 #(
    parameter int DATA_W   = 24,
    parameter int MAX_COLS = 128
) (
    input  logic                clk,
    input  logic                rst_n,
    relu_maxpool_2x2_if.slave   bus
);

    localparam int LB_DEPTH = MAX_COLS / 2;
    localparam int LB_AW    = $clog2(LB_DEPTH);
    // One extra code so the column counter can sit at MAX_COLS once saturated.
    localparam int COL_W    = $clog2(MAX_COLS + 1);
    localparam logic [COL_W-1:0] COL_LIMIT = COL_W'(MAX_COLS);

    logic [COL_W-1:0]  col_q, col_d;
    logic              odd_row_q, odd_row_d;
    logic [DATA_W-1:0] pair_hold_q, pair_hold_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              out_row_end_q, out_row_end_d;
    logic              out_done_q, out_done_d;
    logic              overflow_q, overflow_d;

    logic [DATA_W-1:0] lb [LB_DEPTH];

    logic              accept;
    logic              lb_we;
    logic [LB_AW-1:0]  lb_idx;
    logic [DATA_W-1:0] relu;
    logic [DATA_W-1:0] hmax;
    logic [DATA_W-1:0] lb_rd;
    logic [DATA_W-1:0] pooled;

    // Datapath and next-state logic. A pixel is accepted only while the column
    // counter is inside the row; a row end or frame done is applied after the
    // pixel of the same cycle has been processed, and frame done overrides the
    // row-end parity toggle.
    always_comb begin
        accept = bus.in_valid && (col_q < COL_LIMIT);
        relu   = bus.in_data[DATA_W-1] ? '0 : bus.in_data;
        hmax   = (relu > pair_hold_q) ? relu : pair_hold_q;
        lb_idx = col_q[LB_AW:1];
        lb_rd  = lb[lb_idx];
        pooled = (lb_rd > hmax) ? lb_rd : hmax;
        lb_we  = accept && col_q[0] && !odd_row_q;

        col_d         = col_q;
        odd_row_d     = odd_row_q;
        pair_hold_d   = pair_hold_q;
        out_data_d    = out_data_q;
        out_valid_d   = 1'b0;
        out_row_end_d = 1'b0;
        out_done_d    = bus.in_done;
        overflow_d    = overflow_q;

        if (accept) begin
            col_d = col_q + COL_W'(1);
            if (!col_q[0]) begin
                pair_hold_d = relu;
            end else if (odd_row_q) begin
                out_data_d  = pooled;
                out_valid_d = 1'b1;
            end
        end

        if (bus.in_valid && !accept) begin
            overflow_d = 1'b1;
        end

        if (bus.in_valid && bus.in_row_end) begin
            col_d         = '0;
            odd_row_d     = !odd_row_q;
            out_row_end_d = odd_row_q;
        end

        if (bus.in_done) begin
            col_d     = '0;
            odd_row_d = 1'b0;
        end
    end

    // Control and output registers; everything here returns to zero on reset
    // so a reset mid-frame forgets any half-built pair or row parity.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q         <= '0;
            odd_row_q     <= 1'b0;
            pair_hold_q   <= '0;
            out_data_q    <= '0;
            out_valid_q   <= 1'b0;
            out_row_end_q <= 1'b0;
            out_done_q    <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            col_q         <= col_d;
            odd_row_q     <= odd_row_d;
            pair_hold_q   <= pair_hold_d;
            out_data_q    <= out_data_d;
            out_valid_q   <= out_valid_d;
            out_row_end_q <= out_row_end_d;
            out_done_q    <= out_done_d;
            overflow_q    <= overflow_d;
        end
    end

    // Line buffer storage. It has no reset: every entry is rewritten on an
    // even row before the following odd row reads it, so stale contents are
    // never observed.
    always_ff @(posedge clk) begin
        if (lb_we) begin
            lb[lb_idx] <= hmax;
        end
    end

    assign bus.out_data    = out_data_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_row_end = out_row_end_q;
    assign bus.out_done    = out_done_q;
    assign bus.overflow    = overflow_q;

endmodule
